bus_requester: RTL and testbench

Client-side requester for the two-port grant arbiter of the image-processing datapath. It accepts a burst command, raises `req`, and waits for the arbiter's `gnt`. It then moves `cmd_len` pixels from a valid/ready source onto the shared bus, drops `req`, and waits for `gnt` to fall before reporting completion. One instance attaches to each arbiter port: `req` to `req_0`/`req_1`, `gnt` from `gnt_0`/`gnt_1`.

---
 rtl/bus_requester_if.sv | 27 ++
 rtl/bus_requester.sv | 80 ++++++++
 tb/tb_bus_requester.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_requester_if.sv
// bus_requester_if: command, arbiter, source and bus signals of one requester port.
interface bus_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ready;
  logic              req;
  logic              gnt;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              bus_we;
  logic [DATA_W-1:0] bus_data;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    input  cmd_valid, cmd_len, gnt, src_valid, src_data,
    output cmd_ready, req, src_ready, bus_we, bus_data, busy, done, err
  );
  modport slave (
    output cmd_valid, cmd_len, gnt, src_valid, src_data,
    input  cmd_ready, req, src_ready, bus_we, bus_data, busy, done, err
  );
endinterface

// File: rtl/bus_requester.sv
// bus_requester: requests the arbiter, moves cmd_len source pixels onto the bus,
// then waits for the grant to fall before reporting done (err on abort).
module bus_requester #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic           clock,
  input logic           reset,
  bus_requester_if.master bi
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);
  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [7:0]       cnt, cnt_n;
  logic             abort, abort_n;
  logic             accept, beat, leave;
  assign bi.cmd_ready = state == IDLE;
  assign bi.busy      = state != IDLE;
  assign bi.src_ready = state == XFER && bi.gnt && rem != '0;
  assign accept       = state == IDLE && bi.cmd_valid;
  assign beat         = bi.src_valid && bi.src_ready;
  assign leave        = state == RELEASE && !bi.gnt;
  always_comb begin
    state_n = state;
    rem_n   = rem;
    cnt_n   = cnt;
    abort_n = abort;
    case (state)
      IDLE: if (accept && bi.cmd_len != '0) begin
        state_n = REQ;
        rem_n   = bi.cmd_len;
        cnt_n   = '0;
        abort_n = 1'b0;
      end
      REQ: begin
        cnt_n = cnt == WAIT_MAX ? cnt : cnt + 8'd1;
        if (bi.gnt) state_n = XFER;
        else if (cnt == WAIT_MAX) begin
          state_n = RELEASE;
          abort_n = 1'b1;
        end
      end
      XFER: if (beat) begin
        rem_n   = rem - LEN_W'(1);
        state_n = rem == LEN_W'(1) ? RELEASE : XFER;
      end else if (!bi.gnt) begin
        state_n = RELEASE;
        abort_n = 1'b1;
      end
      RELEASE: state_n = bi.gnt ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // A zero-length command completes from IDLE without ever touching the arbiter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rem         <= '0;
      cnt         <= '0;
      abort       <= 1'b0;
      bi.req      <= 1'b0;
      bi.bus_we   <= 1'b0;
      bi.bus_data <= '0;
      bi.done     <= 1'b0;
      bi.err      <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      cnt         <= cnt_n;
      abort       <= abort_n;
      bi.req      <= state_n == REQ || state_n == XFER;
      bi.bus_we   <= beat;
      bi.bus_data <= beat ? bi.src_data : bi.bus_data;
      bi.done     <= (accept && bi.cmd_len == '0) || leave;
      bi.err      <= leave && abort;
    end
  end
endmodule

// File: tb/tb_bus_requester.sv
// tb_bus_requester: randomized bursts against a 2-cycle grant model and a pixel-order scoreboard.
module tb_bus_requester;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int TO = 16;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic g1, g2;
  logic gnt_off = 1'b0;
  logic [7:0] px [256];
  int errs = 0;
  int checks = 0;
  always #5 clock = ~clock;
  bus_requester_if #(.DATA_W(DW), .LEN_W(LW)) bi ();
  bus_requester #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bi(bi));
  // arbiter model: grant follows req two cycles later, can be forced low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      g1 <= 1'b0;
      g2 <= 1'b0;
    end else begin
      g1 <= bi.req;
      g2 <= g1;
    end
  end
  assign bi.gnt = g2 && !gnt_off;
  int cyc = 0, req_cyc = 0, req_rise = 0, we_n = 0, done_n = 0, err_n = 0, rdy_done = 0;
  int last_req = 0, last_we = 0, done_at = 0;
  logic prev_req = 1'b0;
  logic [7:0] wr [$];
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (bi.req) begin
      req_cyc <= req_cyc + 1;
      last_req <= cyc;
    end
    if (bi.req && !prev_req) req_rise <= req_rise + 1;
    prev_req <= bi.req;
    if (bi.bus_we) begin
      we_n <= we_n + 1;
      wr.push_back(bi.bus_data);
      last_we <= cyc;
    end
    if (bi.done) begin
      done_n <= done_n + 1;
      done_at <= cyc;
      if (bi.cmd_ready) rdy_done <= rdy_done + 1;
    end
    if (bi.err) err_n <= err_n + 1;
  end
  int b_req, b_rise, b_we, b_done, b_err, b_rdy, b_wr;
  task automatic snap();
    b_req = req_cyc; b_rise = req_rise; b_we = we_n; b_done = done_n;
    b_err = err_n; b_rdy = rdy_done; b_wr = wr.size();
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 256; i++) px[i] = 8'($urandom);
  endtask
  function automatic logic [7:0] got_wr(input int i);
    return (b_wr + i < wr.size()) ? wr[b_wr + i] : 8'hxx;
  endfunction
  task automatic drive(input int len, input int prob, input int gap_at, input int gap_n,
                       input int kill_at, input int rst_at, input bit noise, output bit seen);
    int idx, gap, n;
    idx = 0; gap = 0; n = 0; seen = 1'b0;
    @(negedge clock);
    bi.cmd_valid = 1'b1;
    bi.cmd_len = 8'(len);
    @(negedge clock);
    bi.cmd_valid = 1'b0;
    while (n < 300) begin
      if (bi.done) begin
        seen = 1'b1;
        break;
      end
      if (rst_at >= 0 && idx == rst_at) begin
        bi.src_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        break;
      end
      if (kill_at >= 0 && idx >= kill_at) gnt_off = 1'b1;
      if (idx == gap_at && gap < gap_n) begin
        gap++;
        bi.src_valid = 1'b0;
      end else bi.src_valid = idx < len && $urandom_range(99) < prob;
      bi.src_data = px[idx];
      bi.cmd_valid = noise && bi.busy && $urandom_range(1) == 1;
      bi.cmd_len = 8'($urandom);
      #1;
      if (bi.src_valid && bi.src_ready) idx++;
      @(negedge clock);
      n++;
    end
    bi.src_valid = 1'b0;
    bi.cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    bi.cmd_valid = 1'b0; bi.cmd_len = '0; bi.src_valid = 1'b0; bi.src_data = '0;
    #1 reset = 1'b0;
    idle(2);
    checks++; if (bi.req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b expected 0", bi.req); end
    checks++; if (bi.bus_we !== 1'b0) begin errs++; $display("FAIL reset_bus_we: got %b expected 0", bi.bus_we); end
    checks++; if (bi.bus_data !== 8'h00) begin errs++; $display("FAIL reset_bus_data: got %h expected 00", bi.bus_data); end
    checks++; if (bi.done !== 1'b0 || bi.err !== 1'b0) begin errs++; $display("FAIL reset_done_err: got %b%b expected 00", bi.done, bi.err); end
    checks++; if (bi.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bi.busy); end
    checks++; if (bi.src_ready !== 1'b0) begin errs++; $display("FAIL reset_src_ready: got %b expected 0", bi.src_ready); end
    @(negedge clock) reset = 1'b1;
    idle(2);
    checks++; if (bi.cmd_ready !== 1'b1) begin errs++; $display("FAIL idle_cmd_ready: got %b expected 1", bi.cmd_ready); end
  endtask
  task automatic test_basic();
    bit seen;
    for (int i = 0; i < 256; i++) px[i] = 8'((i % 15 + 1) * 17);
    snap();
    drive(4, 100, -1, 0, -1, -1, 1'b0, seen);
    idle(4);
    checks++; if (!seen) begin errs++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (req_cyc - b_req !== 7) begin errs++; $display("FAIL basic_req_cycles: got %0d expected 7", req_cyc - b_req); end
    checks++; if (we_n - b_we !== 4) begin errs++; $display("FAIL basic_writes: got %0d expected 4", we_n - b_we); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_wr(i) !== px[i]) begin errs++; $display("FAIL basic_data%0d: got %h expected %h", i, got_wr(i), px[i]); end
    end
    checks++; if (done_n - b_done !== 1 || err_n - b_err !== 0) begin errs++; $display("FAIL basic_done_err: got %0d/%0d expected 1/0", done_n - b_done, err_n - b_err); end
    checks++; if (rdy_done - b_rdy !== 1) begin errs++; $display("FAIL basic_ready_on_done: got %0d expected 1", rdy_done - b_rdy); end
    checks++; if (done_at - last_we !== 3) begin errs++; $display("FAIL basic_done_lag: got %0d expected 3", done_at - last_we); end
  endtask
  task automatic test_zero_len();
    snap();
    @(negedge clock);
    bi.cmd_valid = 1'b1;
    bi.cmd_len = 8'd0;
    @(negedge clock);
    bi.cmd_valid = 1'b0;
    #1;
    checks++; if (bi.done !== 1'b1 || bi.err !== 1'b0) begin errs++; $display("FAIL zero_done: got %b/%b expected 1/0", bi.done, bi.err); end
    idle(1);
    checks++; if (bi.done !== 1'b0) begin errs++; $display("FAIL zero_done_pulse: got %b expected 0", bi.done); end
    idle(4);
    checks++; if (req_rise - b_rise !== 0) begin errs++; $display("FAIL zero_req: got %0d expected 0", req_rise - b_rise); end
    checks++; if (done_n - b_done !== 1) begin errs++; $display("FAIL zero_done_count: got %0d expected 1", done_n - b_done); end
  endtask
  task automatic test_timeout();
    bit seen;
    fill_rand();
    snap();
    drive(3, 100, -1, 0, 0, -1, 1'b0, seen);
    idle(3);
    gnt_off = 1'b0;
    checks++; if (!seen) begin errs++; $display("FAIL timeout_no_done: got no done expected done"); end
    checks++; if (req_cyc - b_req !== TO) begin errs++; $display("FAIL timeout_req_cycles: got %0d expected %0d", req_cyc - b_req, TO); end
    checks++; if (done_at - last_req !== 2) begin errs++; $display("FAIL timeout_done_lag: got %0d expected 2", done_at - last_req); end
    checks++; if (done_n - b_done !== 1 || err_n - b_err !== 1) begin errs++; $display("FAIL timeout_done_err: got %0d/%0d expected 1/1", done_n - b_done, err_n - b_err); end
    checks++; if (we_n - b_we !== 0) begin errs++; $display("FAIL timeout_writes: got %0d expected 0", we_n - b_we); end
  endtask
  task automatic test_gap();
    bit seen;
    fill_rand();
    snap();
    drive(3, 100, 1, 5, -1, -1, 1'b0, seen);
    idle(4);
    checks++; if (!seen) begin errs++; $display("FAIL gap_no_done: got no done expected done"); end
    checks++; if (req_rise - b_rise !== 1) begin errs++; $display("FAIL gap_req_rises: got %0d expected 1", req_rise - b_rise); end
    checks++; if (req_cyc - b_req !== 11) begin errs++; $display("FAIL gap_req_cycles: got %0d expected 11", req_cyc - b_req); end
    checks++; if (we_n - b_we !== 3) begin errs++; $display("FAIL gap_writes: got %0d expected 3", we_n - b_we); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_wr(i) !== px[i]) begin errs++; $display("FAIL gap_data%0d: got %h expected %h", i, got_wr(i), px[i]); end
    end
    checks++; if (err_n - b_err !== 0) begin errs++; $display("FAIL gap_err: got %0d expected 0", err_n - b_err); end
  endtask
  task automatic test_abort();
    bit seen;
    fill_rand();
    snap();
    drive(6, 100, -1, 0, 2, -1, 1'b0, seen);
    idle(3);
    gnt_off = 1'b0;
    idle(3);
    checks++; if (!seen) begin errs++; $display("FAIL abort_no_done: got no done expected done"); end
    checks++; if (we_n - b_we !== 2) begin errs++; $display("FAIL abort_writes: got %0d expected 2", we_n - b_we); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (got_wr(i) !== px[i]) begin errs++; $display("FAIL abort_data%0d: got %h expected %h", i, got_wr(i), px[i]); end
    end
    checks++; if (done_n - b_done !== 1 || err_n - b_err !== 1) begin errs++; $display("FAIL abort_done_err: got %0d/%0d expected 1/1", done_n - b_done, err_n - b_err); end
    checks++; if (bi.gnt !== 1'b0) begin errs++; $display("FAIL abort_stale_gnt: got %b expected 0", bi.gnt); end
    fill_rand();
    snap();
    drive(1, 100, -1, 0, -1, -1, 1'b0, seen);
    idle(4);
    checks++; if (!seen) begin errs++; $display("FAIL after_abort_no_done: got no done expected done"); end
    checks++; if (we_n - b_we !== 1 || got_wr(0) !== px[0]) begin errs++; $display("FAIL after_abort_write: got %0d/%h expected 1/%h", we_n - b_we, got_wr(0), px[0]); end
    checks++; if (err_n - b_err !== 0) begin errs++; $display("FAIL after_abort_err: got %0d expected 0", err_n - b_err); end
  endtask
  task automatic test_reset_mid();
    bit seen;
    fill_rand();
    drive(8, 100, -1, 0, -1, 3, 1'b0, seen);
    checks++; if (bi.req !== 1'b0 || bi.busy !== 1'b0) begin errs++; $display("FAIL mid_req_busy: got %b/%b expected 0/0", bi.req, bi.busy); end
    checks++; if (bi.bus_we !== 1'b0 || bi.bus_data !== 8'h00) begin errs++; $display("FAIL mid_bus: got %b/%h expected 0/00", bi.bus_we, bi.bus_data); end
    checks++; if (bi.done !== 1'b0 || bi.err !== 1'b0) begin errs++; $display("FAIL mid_done_err: got %b/%b expected 0/0", bi.done, bi.err); end
    checks++; if (bi.cmd_ready !== 1'b1) begin errs++; $display("FAIL mid_cmd_ready: got %b expected 1", bi.cmd_ready); end
    snap();
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    idle(4);
    checks++; if (done_n - b_done !== 0 || err_n - b_err !== 0) begin errs++; $display("FAIL mid_no_done: got %0d/%0d expected 0/0", done_n - b_done, err_n - b_err); end
    fill_rand();
    snap();
    drive(2, 100, -1, 0, -1, -1, 1'b0, seen);
    idle(4);
    checks++; if (!seen) begin errs++; $display("FAIL post_reset_no_done: got no done expected done"); end
    checks++; if (we_n - b_we !== 2) begin errs++; $display("FAIL post_reset_writes: got %0d expected 2", we_n - b_we); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (got_wr(i) !== px[i]) begin errs++; $display("FAIL post_reset_data%0d: got %h expected %h", i, got_wr(i), px[i]); end
    end
    checks++; if (err_n - b_err !== 0) begin errs++; $display("FAIL post_reset_err: got %0d expected 0", err_n - b_err); end
  endtask
  task automatic test_random();
    bit seen;
    int len, prob, bad;
    for (int k = 0; k < 10; k++) begin
      len = $urandom_range(20, 1);
      prob = $urandom_range(100, 40);
      fill_rand();
      snap();
      drive(len, prob, -1, 0, -1, -1, 1'b1, seen);
      idle(4);
      checks++; if (!seen) begin errs++; $display("FAIL rand%0d_no_done: got no done expected done", k); end
      checks++; if (we_n - b_we !== len) begin errs++; $display("FAIL rand%0d_writes: got %0d expected %0d", k, we_n - b_we, len); end
      bad = 0;
      for (int i = 0; i < len; i++) if (got_wr(i) !== px[i]) bad++;
      checks++; if (bad !== 0) begin errs++; $display("FAIL rand%0d_data: got %0d wrong pixels expected 0", k, bad); end
      checks++; if (done_n - b_done !== 1 || err_n - b_err !== 0) begin errs++; $display("FAIL rand%0d_done_err: got %0d/%0d expected 1/0", k, done_n - b_done, err_n - b_err); end
      checks++; if (req_rise - b_rise !== 1) begin errs++; $display("FAIL rand%0d_req_rises: got %0d expected 1", k, req_rise - b_rise); end
      checks++; if (done_at - last_we !== 3) begin errs++; $display("FAIL rand%0d_done_lag: got %0d expected 3", k, done_at - last_we); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_timeout();
    test_gap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
